c499_lock_sched: RTL and testbench
==================================

Name: c499_lock_sched

Overview:
- Sequencing controller for the key-locked c499 32-bit single-error-correcting datapath.
- Loads and commits the 25-bit unlock key: 4 mux-select bits plus 21 XOR key bits.
- Round-robin arbitrates the shared combinational correction core between two requesters and returns registered corrected words with a valid/ready handshake.
- Sits between the requesters and the combinational core instance; the core's key inputs are driven only from this block.

Parameters:
- SETTLE_CYC, 1: cycles core inputs are held stable before core_dout is sampled; legal range 1..15.
- KEY_LEN, 25: serial key length; fixed as 4 mux bits plus 21 XOR bits, not intended to change.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- key_sdi  in  1  serial key data, LSB first
- key_sen  in  1  key shift enable
- key_commit  in  1  commit the shifted key, single-cycle pulse
- key_ok  out  1  an active key is committed
- key_err  out  1  one-cycle error pulse
- req0_valid / req1_valid  in  1  request valid
- req0_ready / req1_ready  out  1  request accepted
- req0_data / req1_data  in  32  received data word
- req0_chk / req1_chk  in  8  received check bits
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_data  out  32  corrected word
- rsp_id  out  1  requester index
- core_din  out  32  to core data inputs
- core_chk  out  8  to core check inputs
- core_en  out  1  to core enable (N137)
- core_key_mux  out  4  to core mux key p1..p4
- core_key_xor  out  21  to core XOR key X_1..X_21
- core_dout  in  32  from core corrected outputs

Behaviour:
- Reset values: all outputs 0; state LOCKED; shift register and bit counter 0; round-robin pointer favours req0.
- States: LOCKED, IDLE, ISSUE, WAIT, RESP.
- Key shift: each cycle with key_sen=1, shift key_sdi into bit 24 and shift the register right. The bit counter saturates at 31.
  - Shifting is allowed only in LOCKED or IDLE.
  - key_sen in ISSUE, WAIT or RESP: ignored, and key_err pulses.
- Key commit: key_commit with counter == 25 copies shift[3:0] to core_key_mux and shift[24:4] to core_key_xor on the next edge, sets key_ok=1, clears the counter, and moves LOCKED to IDLE.
  - Commit with counter != 25: no change to the active key, key_err pulses, counter cleared.
  - key_sen and key_commit in the same cycle: the shift happens first; the commit is evaluated against the pre-shift count.
- LOCKED: req*_ready=0 and core_en=0.
- IDLE, arbitration:
  - Grant is combinational from the valids.
  - One requester valid: that requester wins.
  - Both valid: the requester not granted last wins.
  - reqN_ready=1 only for the granted requester, only in IDLE.
- Accept (valid & ready): register data/chk onto core_din/core_chk, set core_en=1, latch rsp_id; go to ISSUE.
- ISSUE -> WAIT; the WAIT counter loads SETTLE_CYC-1.
- WAIT: on count 0, sample core_dout into rsp_data, set rsp_valid=1, go to RESP; otherwise decrement.
  - Accept-to-rsp_valid latency = SETTLE_CYC+2 cycles.
- RESP: rsp_data and rsp_id held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready=1: rsp_valid=0, core_en=0, go to IDLE. The next accept can occur the following cycle.
- Core inputs: core_din and core_chk retain their last values outside a transaction. core_en=1 only in ISSUE, WAIT and RESP.
- Throughput: one transaction in flight; maximum one response per SETTLE_CYC+3 cycles.
- Reset mid-operation: immediate return to LOCKED; the key is lost and any pending response is dropped.

Optional Feature:
- C499_KEY_ZEROIZE_EN defined: adds input key_zeroize (1 bit).
  - In LOCKED or IDLE: clears the active key, shift register and key_ok next edge; state becomes LOCKED.
  - In ISSUE, WAIT or RESP: latched, and applied when RESP completes.
- Undefined: the port is absent, and the key persists until rst.

Test Plan:
- Reset, then req0_valid=1 with no key -> req0_ready stays 0, key_ok=0, core_en=0.
- Shift 25 bits 0x1A5_A5A5, then commit -> core_key_mux=0x5, core_key_xor=0x1A5A5A, key_ok=1, state IDLE.
- Shift 24 bits, then commit -> key_err one-cycle pulse, key_ok unchanged, core keys unchanged.
- SETTLE_CYC=1, req0 data=0xDEADBEEF chk=0x3C, core model returning data^0x1 -> rsp_valid 3 cycles after accept, rsp_data=0xDEADBEEE, rsp_id=0.
- Both requesters continuously valid, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_ready held low 5 cycles -> rsp_data stable, no new accept.
- key_sen during WAIT -> key_err pulse, shift register unchanged; rst asserted in WAIT -> all outputs 0 asynchronously, state LOCKED.

Source files
------------

// File: rtl/c499_lock_sched.sv
// Key-load and request sequencer for the key-locked c499 single-error-correcting core.
// Optional build macro C499_KEY_ZEROIZE_EN adds the key_zeroize input.
module c499_lock_sched #(
  parameter int unsigned SETTLE_CYC = 1,
  parameter int unsigned KEY_LEN    = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_sdi,
  input  logic        key_sen,
  input  logic        key_commit,
`ifdef C499_KEY_ZEROIZE_EN
  input  logic        key_zeroize,
`endif
  output logic        key_ok,
  output logic        key_err,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_data,
  input  logic [31:0] req1_data,
  input  logic [7:0]  req0_chk,
  input  logic [7:0]  req1_chk,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_id,
  output logic [31:0] core_din,
  output logic [7:0]  core_chk,
  output logic        core_en,
  output logic [3:0]  core_key_mux,
  output logic [20:0] core_key_xor,
  input  logic [31:0] core_dout
);

  typedef enum logic [2:0] {StLocked, StIdle, StIssue, StWait, StResp} state_e;

  localparam logic [4:0] KeyCnt  = 5'(KEY_LEN);
  localparam logic [3:0] WaitLd  = 4'(SETTLE_CYC - 1);

  state_e               state_q;
  logic [KEY_LEN-1:0]   shift_q;
  logic [4:0]           cnt_q;
  logic [3:0]           wait_q;
  logic                 last_q;
  logic                 zpend_q;

  logic zeroize_in;
  logic key_phase;
  logic idle_open;
  logic grant_id;
  logic accept;
  logic zero_apply;

`ifdef C499_KEY_ZEROIZE_EN
  assign zeroize_in = key_zeroize;
`else
  assign zeroize_in = 1'b0;
`endif

  assign key_phase = (state_q == StLocked) || (state_q == StIdle);
  assign idle_open = (state_q == StIdle) && !zeroize_in;

  // Contention goes to whoever was not served last; a lone requester always wins.
  assign grant_id   = (req0_valid && req1_valid) ? ~last_q : req1_valid;
  assign req0_ready = idle_open && req0_valid && !grant_id;
  assign req1_ready = idle_open && req1_valid && grant_id;
  assign accept     = req0_ready || req1_ready;

  // A zeroize seen mid-transaction waits until the response has been consumed.
  assign zero_apply = (zeroize_in && key_phase) ||
                      ((state_q == StResp) && rsp_ready && (zpend_q || zeroize_in));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StLocked;
      shift_q      <= '0;
      cnt_q        <= '0;
      wait_q       <= '0;
      last_q       <= 1'b1;
      zpend_q      <= 1'b0;
      key_ok       <= 1'b0;
      key_err      <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_id       <= 1'b0;
      core_din     <= '0;
      core_chk     <= '0;
      core_en      <= 1'b0;
      core_key_mux <= '0;
      core_key_xor <= '0;
    end else begin
      key_err <= 1'b0;

      if (key_sen) begin
        if (key_phase) begin
          shift_q <= {key_sdi, shift_q[KEY_LEN-1:1]};
          if (cnt_q != 5'd31) cnt_q <= cnt_q + 5'd1;
        end else begin
          key_err <= 1'b1;
        end
      end

      // Commit judges the pre-shift count and copies the pre-shift register.
      if (key_commit) begin
        cnt_q <= '0;
        if (key_phase && (cnt_q == KeyCnt)) begin
          core_key_mux <= shift_q[3:0];
          core_key_xor <= shift_q[KEY_LEN-1:4];
          key_ok       <= 1'b1;
          if (state_q == StLocked) state_q <= StIdle;
        end else begin
          key_err <= 1'b1;
        end
      end

      unique case (state_q)
        StLocked: ;
        StIdle: begin
          if (accept) begin
            core_din <= grant_id ? req1_data : req0_data;
            core_chk <= grant_id ? req1_chk : req0_chk;
            core_en  <= 1'b1;
            rsp_id   <= grant_id;
            last_q   <= grant_id;
            state_q  <= StIssue;
          end
        end
        StIssue: begin
          wait_q  <= WaitLd;
          state_q <= StWait;
        end
        StWait: begin
          if (wait_q == 4'd0) begin
            rsp_data  <= core_dout;
            rsp_valid <= 1'b1;
            state_q   <= StResp;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            core_en   <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StLocked;
      endcase

      if (zeroize_in && !key_phase && !zero_apply) zpend_q <= 1'b1;
      if (zero_apply) begin
        core_key_mux <= '0;
        core_key_xor <= '0;
        shift_q      <= '0;
        cnt_q        <= '0;
        key_ok       <= 1'b0;
        zpend_q      <= 1'b0;
        state_q      <= StLocked;
      end
    end
  end

endmodule

// File: tb/tb_c499_lock_sched.sv
// Directed bench for c499_lock_sched: vector table for arbitration plus key and reset sequences.
module tb_c499_lock_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_sdi, key_sen, key_commit;
  logic        key_ok, key_err;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_data, req1_data;
  logic [7:0]  req0_chk, req1_chk;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_data, core_din, core_dout;
  logic [7:0]  core_chk;
  logic        core_en;
  logic [3:0]  core_key_mux;
  logic [20:0] core_key_xor;

  always #5 clk = ~clk;

  // Stand-in correction core: flips bit 0.
  assign core_dout = core_din ^ 32'h1;

  c499_lock_sched #(.SETTLE_CYC(1), .KEY_LEN(25)) dut (
    .clk(clk), .rst(rst), .key_sdi(key_sdi), .key_sen(key_sen), .key_commit(key_commit),
    .key_ok(key_ok), .key_err(key_err),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_data(req0_data), .req1_data(req1_data), .req0_chk(req0_chk), .req1_chk(req1_chk),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .core_din(core_din), .core_chk(core_chk), .core_en(core_en),
    .core_key_mux(core_key_mux), .core_key_xor(core_key_xor), .core_dout(core_dout)
  );

  typedef struct {
    logic        v0, v1, rr;
    logic        r0, r1;
    logic        en, rv, kok, cd, id;
    logic [31:0] data;
  } vec_t;

  vec_t tbl[11];
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_key(input logic [24:0] val, input int n);
    for (int i = 0; i < n; i++) begin
      key_sen = 1'b1;
      key_sdi = val[i];
      tick();
    end
    key_sen = 1'b0;
    key_sdi = 1'b0;
  endtask

  task automatic commit_key();
    key_commit = 1'b1;
    tick();
    key_commit = 1'b0;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      req0_valid = tbl[i].v0;
      req1_valid = tbl[i].v1;
      rsp_ready  = tbl[i].rr;
      #1;
      chk($sformatf("row%0d req0_ready", i), req0_ready, tbl[i].r0);
      chk($sformatf("row%0d req1_ready", i), req1_ready, tbl[i].r1);
      tick();
      chk($sformatf("row%0d core_en", i), core_en, tbl[i].en);
      chk($sformatf("row%0d rsp_valid", i), rsp_valid, tbl[i].rv);
      chk($sformatf("row%0d key_ok", i), key_ok, tbl[i].kok);
      if (tbl[i].cd) begin
        chk($sformatf("row%0d rsp_id", i), rsp_id, tbl[i].id);
        chk($sformatf("row%0d rsp_data", i), rsp_data, tbl[i].data);
      end
    end
  endtask

  initial begin
    //          v0    v1    rr    r0    r1    en    rv    kok   cd    id    data
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    // Both valid, rsp_ready high: req0 was served last, so req1 goes first.
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h22222223};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h11111110};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};

    rst = 1'b1;
    key_sdi = 1'b0; key_sen = 1'b0; key_commit = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_data = '0; req1_data = '0; req0_chk = '0; req1_chk = '0;
    repeat (2) tick();

    chk("reset key_ok", key_ok, 0);
    chk("reset key_err", key_err, 0);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset core_en", core_en, 0);
    chk("reset core_key_mux", core_key_mux, 0);
    chk("reset core_key_xor", core_key_xor, 0);
    chk("reset core_din", core_din, 0);
    rst = 1'b0;

    // No key loaded: requests are ignored.
    run_rows(0, 2);
    req0_valid = 1'b0;

    shift_key(25'h1A5A5A5, 25);
    commit_key();
    chk("commit key_ok", key_ok, 1);
    chk("commit key_err", key_err, 0);
    chk("commit core_key_mux", core_key_mux, 32'h5);
    chk("commit core_key_xor", core_key_xor, 32'h1A5A5A);

    // Short key: error pulse, active key untouched.
    shift_key(25'h1FFFFFF, 24);
    commit_key();
    chk("short key_err pulse", key_err, 1);
    chk("short key_ok", key_ok, 1);
    chk("short core_key_mux", core_key_mux, 32'h5);
    chk("short core_key_xor", core_key_xor, 32'h1A5A5A);
    tick();
    chk("short key_err clears", key_err, 0);

    // Single transaction latency.
    req0_data = 32'hDEADBEEF;
    req0_chk  = 8'h3C;
    req0_valid = 1'b1;
    #1;
    chk("single req0_ready", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    chk("single core_din", core_din, 32'hDEADBEEF);
    chk("single core_chk", core_chk, 32'h3C);
    chk("single core_en", core_en, 1);
    chk("single rsp_valid +1", rsp_valid, 0);
    tick();
    chk("single rsp_valid +2", rsp_valid, 0);
    tick();
    chk("single rsp_valid +3", rsp_valid, 1);
    chk("single rsp_data", rsp_data, 32'hDEADBEEE);
    chk("single rsp_id", rsp_id, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("single rsp_valid done", rsp_valid, 0);
    chk("single core_en done", core_en, 0);

    req0_data = 32'h11111111;
    req1_data = 32'h22222222;
    run_rows(3, 10);

    // Back-pressure: response held while rsp_ready is low.
    rsp_ready = 1'b0;
    #1;
    chk("hold req1_ready", req1_ready, 1);
    repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      req0_data = 32'h33333333 + i;
      req1_data = 32'h44444444 + i;
      #1;
      chk("hold req0_ready", req0_ready, 0);
      chk("hold req1_ready busy", req1_ready, 0);
      chk("hold rsp_valid", rsp_valid, 1);
      chk("hold rsp_data", rsp_data, 32'h22222223);
      chk("hold rsp_id", rsp_id, 1);
      chk("hold core_din", core_din, 32'h22222222);
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("hold release rsp_valid", rsp_valid, 0);
    chk("hold release core_en", core_en, 0);

    // key_sen while busy: error pulse and no shift.
    req0_data  = 32'hCAFEF00D;
    req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    tick();
    key_sen = 1'b1;
    key_sdi = 1'b1;
    tick();
    key_sen = 1'b0;
    key_sdi = 1'b0;
    chk("busy key_err", key_err, 1);
    chk("busy rsp_valid", rsp_valid, 1);
    chk("busy rsp_data", rsp_data, 32'hCAFEF00C);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("busy key_err clears", key_err, 0);
    chk("busy rsp done", rsp_valid, 0);
    shift_key(25'h0F0F0F3, 25);
    commit_key();
    chk("rekey key_err", key_err, 0);
    chk("rekey core_key_mux", core_key_mux, 32'h3);
    chk("rekey core_key_xor", core_key_xor, 32'h0F0F0F);

    // Asynchronous reset in WAIT.
    req0_data  = 32'h12345678;
    req0_valid = 1'b1;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst key_ok", key_ok, 0);
    chk("arst core_en", core_en, 0);
    chk("arst core_din", core_din, 0);
    chk("arst core_key_mux", core_key_mux, 0);
    chk("arst core_key_xor", core_key_xor, 0);
    chk("arst rsp_valid", rsp_valid, 0);
    chk("arst req0_ready", req0_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    chk("arst locked req0_ready", req0_ready, 0);
    chk("arst locked rsp_valid", rsp_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
